// File: rtl/key_operand_sequencer.sv
// Debounced push-button front end that produces the registered operand A for the
// DE2 function-block demos: loaded from SW, stepped by hand, or swept automatically.
module key_operand_sequencer #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int STEP_CYCLES     = 25000000
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic [2:0]       KEY_N,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] A,
  output logic             auto_mode,
  output logic             step_pulse,
  output logic             wrap
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int PW = $clog2(STEP_CYCLES);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] STEP_LAST = PW'(STEP_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_MANUAL = 1'b0,
    ST_AUTO   = 1'b1
  } state_t;

  logic [2:0]         sync1_q;
  logic [2:0]         sync2_q;
  logic [2:0]         deb_q;
  logic [2:0]         deb_d;
  logic [2:0]         press_q;
  logic [2:0]         press_d;
  logic [2:0][DW-1:0] cnt_q;
  logic [2:0][DW-1:0] cnt_d;

  state_t             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [PW-1:0]      presc_q;
  logic               step_q;
  logic               wrap_q;

  logic               step_ev_s;
  logic               load_ev_s;
  logic               mode_ev_s;
  logic [WIDTH-1:0]   a_inc_s;
  logic               a_max_s;
  logic               tick_s;

  // Debounce next state: a level is accepted after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    deb_d   = deb_q;
    press_d = 3'b000;
    cnt_d   = '0;
    for (int k = 0; k < 3; k++) begin
      if (sync2_q[k] == deb_q[k]) begin
        cnt_d[k] = '0;
      end else if (cnt_q[k] == DEB_LAST) begin
        cnt_d[k]   = '0;
        deb_d[k]   = sync2_q[k];
        press_d[k] = ~sync2_q[k];
      end else begin
        cnt_d[k] = cnt_q[k] + DW'(1);
      end
    end
  end

  // Key synchronizers, debounced levels and one-cycle press events.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      sync1_q <= 3'b111;
      sync2_q <= 3'b111;
      deb_q   <= 3'b111;
      cnt_q   <= '0;
      press_q <= 3'b000;
    end else begin
      sync1_q <= KEY_N;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign step_ev_s = press_q[0];
  assign load_ev_s = press_q[1];
  assign mode_ev_s = press_q[2];
  assign a_inc_s   = a_q + WIDTH'(1);
  assign a_max_s   = (a_q == {WIDTH{1'b1}});
  assign tick_s    = (presc_q == STEP_LAST);

  // Mode FSM and operand register; load beats mode beats step/tick, losers are dropped.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_MANUAL;
      a_q     <= '0;
      presc_q <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      step_q <= 1'b0;
      wrap_q <= 1'b0;
      if (load_ev_s) begin
        a_q     <= SW;
        step_q  <= 1'b1;
        presc_q <= '0;
      end else if (mode_ev_s) begin
        state_q <= (state_q == ST_AUTO) ? ST_MANUAL : ST_AUTO;
        presc_q <= '0;
      end else begin
        case (state_q)
          ST_MANUAL: begin
            presc_q <= '0;
            if (step_ev_s) begin
              a_q    <= a_inc_s;
              step_q <= 1'b1;
              wrap_q <= a_max_s;
            end else begin
              a_q <= a_q;
            end
          end
          ST_AUTO: begin
            if (tick_s) begin
              presc_q <= '0;
              a_q     <= a_inc_s;
              step_q  <= 1'b1;
              wrap_q  <= a_max_s;
            end else begin
              presc_q <= presc_q + PW'(1);
            end
          end
          default: begin
            state_q <= ST_MANUAL;
            presc_q <= '0;
          end
        endcase
      end
    end
  end

  assign A          = a_q;
  assign auto_mode  = (state_q == ST_AUTO);
  assign step_pulse = step_q;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_key_operand_sequencer.sv
// Directed bench for key_operand_sequencer with a window-based reference model
// compared every cycle, plus hand-computed literal expectations.
module tb_key_operand_sequencer;
  localparam int W    = 4;
  localparam int DEB  = 4;
  localparam int STEP = 8;

  logic         CLOCK_50 = 1'b0;
  logic         RESET    = 1'b1;
  logic [2:0]   KEY_N    = 3'b111;
  logic [W-1:0] SW       = 4'hA;
  logic [W-1:0] A;
  logic         auto_mode;
  logic         step_pulse;
  logic         wrap;

  int errors = 0;
  int checks = 0;
  bit en     = 1'b0;

  key_operand_sequencer #(
    .WIDTH(W), .DEBOUNCE_CYCLES(DEB), .STEP_CYCLES(STEP)
  ) dut (
    .CLOCK_50(CLOCK_50), .RESET(RESET), .KEY_N(KEY_N), .SW(SW),
    .A(A), .auto_mode(auto_mode), .step_pulse(step_pulse), .wrap(wrap)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a key level is accepted once the last DEB synchronized
  // samples (raw KEY_N two edges back) all differ from the accepted level;
  // the resulting event acts on the following edge.
  logic [2:0]   raw_h1, raw_h2, deb, pend;
  logic [2:0]   hist [DEB];
  logic [W-1:0] m_A;
  logic         m_auto, m_step, m_wrap;
  int           cyc, next_tick;

  task automatic model_step();
    logic [2:0] s;
    bit         same;
    if (RESET) begin
      raw_h1 = 3'b111; raw_h2 = 3'b111; deb = 3'b111; pend = 3'b000;
      for (int i = 0; i < DEB; i++) hist[i] = 3'b111;
      m_A = 4'h0; m_auto = 1'b0; m_step = 1'b0; m_wrap = 1'b0;
      cyc = 0; next_tick = 0;
    end else begin
      cyc++;
      m_step = 1'b0;
      m_wrap = 1'b0;
      if (pend[1]) begin
        m_A = SW; m_step = 1'b1;
        next_tick = cyc + STEP;
      end else if (pend[2]) begin
        m_auto = ~m_auto;
        next_tick = cyc + STEP;
      end else if (m_auto ? (cyc == next_tick) : pend[0]) begin
        m_wrap = (m_A == 4'hF);
        m_A = m_A + 4'd1;
        m_step = 1'b1;
        next_tick = cyc + STEP;
      end
      s = raw_h2; raw_h2 = raw_h1; raw_h1 = KEY_N;
      for (int i = 0; i < DEB - 1; i++) hist[i] = hist[i+1];
      hist[DEB-1] = s;
      pend = 3'b000;
      for (int k = 0; k < 3; k++) begin
        same = 1'b1;
        for (int i = 0; i < DEB; i++) if (hist[i][k] == deb[k]) same = 1'b0;
        if (same) begin
          deb[k]  = ~deb[k];
          pend[k] = ~deb[k];
        end
      end
    end
  endtask

  initial forever begin
    @(posedge CLOCK_50 or posedge RESET);
    model_step();
  end

  always @(negedge CLOCK_50) begin
    if (en && !RESET) begin
      chk("cmp_A",          32'(A),          32'(m_A));
      chk("cmp_auto_mode",  32'(auto_mode),  32'(m_auto));
      chk("cmp_step_pulse", 32'(step_pulse), 32'(m_step));
      chk("cmp_wrap",       32'(wrap),       32'(m_wrap));
    end
  end

  task automatic cyc_n(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic bounce_lows();
    KEY_N[0] = 1'b0; cyc_n(2); KEY_N[0] = 1'b1; cyc_n(2);
    KEY_N[0] = 1'b0; cyc_n(2); KEY_N[0] = 1'b1; cyc_n(2);
  endtask

  initial begin
    int steps;
    int wraps;
    cyc_n(3);
    chk("reset_A",    32'(A),          32'h0);
    chk("reset_auto", 32'(auto_mode),  32'h0);
    chk("reset_step", 32'(step_pulse), 32'h0);
    chk("reset_wrap", 32'(wrap),       32'h0);
    RESET = 1'b0;
    en    = 1'b1;
    cyc_n(4);

    bounce_lows();
    KEY_N[0] = 1'b0;
    cyc_n(6);
    chk("step1_edge5_A", 32'(A), 32'h0);
    cyc_n(1);
    chk("step1_edge6_A",    32'(A),          32'h1);
    chk("step1_edge6_step", 32'(step_pulse), 32'h1);
    cyc_n(13);
    KEY_N[0] = 1'b1;
    cyc_n(10);
    for (int r = 0; r < 4; r++) begin
      bounce_lows();
      KEY_N[0] = 1'b0; cyc_n(20);
      KEY_N[0] = 1'b1; cyc_n(10);
    end
    chk("manual_five_A", 32'(A), 32'h5);

    SW = 4'h7;
    KEY_N[1] = 1'b0; cyc_n(3);
    KEY_N[1] = 1'b1; cyc_n(10);
    chk("glitch_A", 32'(A), 32'h5);
    KEY_N[1] = 1'b0; cyc_n(10);
    KEY_N[1] = 1'b1; cyc_n(10);
    chk("load7_A", 32'(A), 32'h7);

    KEY_N[2] = 1'b0;
    for (int i = 0; i < 40 && !auto_mode; i++) cyc_n(1);
    chk("auto_on", 32'(auto_mode), 32'h1);
    KEY_N[2] = 1'b1;
    steps = 0;
    wraps = 0;
    for (int i = 0; i < 16 * STEP; i++) begin
      if (i == 20) KEY_N[0] = 1'b0;
      if (i == 35) KEY_N[0] = 1'b1;
      cyc_n(1);
      if (step_pulse) steps++;
      if (wrap) wraps++;
    end
    chk("sweep_steps", 32'(steps), 32'd16);
    chk("sweep_wraps", 32'(wraps), 32'd1);
    cyc_n(5);

    SW = 4'h3;
    KEY_N[1] = 1'b0; KEY_N[2] = 1'b0;
    cyc_n(7);
    chk("prio_A",    32'(A),         32'h3);
    chk("prio_auto", 32'(auto_mode), 32'h1);
    KEY_N = 3'b111;
    cyc_n(10);

    SW = 4'hE;
    KEY_N[1] = 1'b0;
    cyc_n(7);
    chk("loadE_A",    32'(A),          32'hE);
    chk("loadE_step", 32'(step_pulse), 32'h1);
    chk("loadE_wrap", 32'(wrap),       32'h0);
    KEY_N[1] = 1'b1;
    cyc_n(8);
    chk("afterE_A",    32'(A),          32'hF);
    chk("afterE_step", 32'(step_pulse), 32'h1);
    cyc_n(8);
    chk("wrap_A",    32'(A),    32'h0);
    chk("wrap_flag", 32'(wrap), 32'h1);

    for (int i = 0; i < 200 && A != 4'h5; i++) cyc_n(1);
    chk("sweep_reach5", 32'(A), 32'h5);
    KEY_N[0] = 1'b0;
    #2 RESET = 1'b1;
    #1;
    chk("async_reset_A",    32'(A),         32'h0);
    chk("async_reset_auto", 32'(auto_mode), 32'h0);
    @(negedge CLOCK_50);
    #2 RESET = 1'b0;
    cyc_n(6);
    chk("held_edge5_A", 32'(A), 32'h0);
    cyc_n(1);
    chk("held_edge6_A",    32'(A),          32'h1);
    chk("held_edge6_step", 32'(step_pulse), 32'h1);
    cyc_n(20);
    chk("held_no_repeat_A", 32'(A), 32'h1);
    KEY_N[0] = 1'b1;
    cyc_n(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/key_operand_sequencer.md
Name: key_operand_sequencer

Overview:
- Input-side counterpart to the switch → logic → 7-seg display path on the DE2 board.
- Turns raw, bouncing push buttons into clean events and produces the registered 4-bit operand A that feeds the combinational function blocks.
- Operand source: loaded from SW, stepped by hand, or auto-swept through all 2^WIDTH input combinations so every truth-table row can be seen on the HEX displays.

Parameters:
- WIDTH, 4: operand width in bits.
- DEBOUNCE_CYCLES, 1000000: number of consecutive stable synchronized samples needed to accept a button level (20 ms at 50 MHz). Must be ≥ 2.
- STEP_CYCLES, 25000000: auto-mode period between increments (0.5 s at 50 MHz). Must be ≥ 2.

Ports:
- CLOCK_50, input, 1: system clock, 50 MHz.
- RESET, input, 1: reset, asynchronous, active-high.
- KEY_N, input, 3: raw push buttons, active-low. [0] = step, [1] = load, [2] = mode toggle.
- SW, input, WIDTH: value loaded into A on a load event.
- A, output, WIDTH: registered operand to the downstream logic.
- auto_mode, output, 1: 1 = AUTO state, 0 = MANUAL state.
- step_pulse, output, 1: one-cycle pulse in the same cycle A shows a new value (increment or load).
- wrap, output, 1: one-cycle pulse when an increment takes A from all-ones to 0.

Behaviour:
- **Clock and reset (already decided):** single clock CLOCK_50. RESET is asynchronous, active-high.
- **Reset values:**
  - A = 0, auto_mode = 0, step_pulse = 0, wrap = 0.
  - Synchronizer flops = 1, debounced levels = 1 (released).
  - Debounce counters = 0, prescaler = 0, FSM = MANUAL.
  - Asserting RESET mid-debounce or mid-sweep discards all progress.
- **Synchronizer:** each KEY_N bit passes through a 2-flop synchronizer.
- **Debounce, per key:**
  - The counter clears whenever the synchronized level equals the debounced level. Otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while the levels still differ, the debounced level flips and the counter clears.
  - A press event is a one-cycle pulse on a debounced 1→0 transition. Releases generate no event.
  - A held button gives exactly one event.
  - A glitch shorter than DEBOUNCE_CYCLES samples gives no event.
  - A button held low across RESET deassertion gives one event once debounce completes.
- **Latency:** the first synchronizer flop samples KEY_N low at edge 0, and the key stays low. Then A and step_pulse update at edge DEBOUNCE_CYCLES+2, with no cycle tolerance.
- **FSM states:** MANUAL, AUTO.
  - Mode event: MANUAL ↔ AUTO, prescaler cleared to 0.
  - MANUAL: step event → A = A+1 mod 2^WIDTH.
  - AUTO: step events are ignored. The prescaler counts 0..STEP_CYCLES-1. At the terminal count it wraps to 0 and A = A+1 mod 2^WIDTH.
  - Load event (either state): A = SW. In AUTO the prescaler also clears. State is unchanged.
- **Simultaneous events in one cycle:** load has top priority, then mode, then step/tick. A lower-priority event in the same cycle is dropped, not queued.
  - Load with mode: load is taken, mode is dropped.
  - Mode with a prescaler terminal count: toggle only, no increment.
- **step_pulse:** asserted for every load and every increment, including a load of the value already in A.
- **wrap:** asserted only on an increment from all-ones to 0, in the same cycle as step_pulse. It is never asserted on a load.
- **Outputs:** all outputs are registered. There is no combinational path from KEY_N or SW to any output.

Test Plan (DEBOUNCE_CYCLES = 4, STEP_CYCLES = 8):
- **Reset:** assert RESET while KEY_N = 3'b111 and SW = 4'hA → A = 0, auto_mode = 0, step_pulse = 0, wrap = 0. Assert RESET again mid-sweep with A = 5 → A = 0 immediately, before any clock edge.
- **Manual step with bounce:** KEY_N[0] toggles 1-0-1-0 with 2-cycle lows, then holds low for 20 cycles → exactly one step_pulse, A 0→1, at edge 6 after the last falling sample. Release and repeat four more times → A = 5.
- **Glitch reject:** KEY_N[1] low for 3 cycles with SW = 4'h7 → no step_pulse, A unchanged. Low for 10 cycles → A = 7 with one step_pulse.
- **Auto sweep:** press mode → auto_mode = 1. A increments every 8 cycles through 0..F. wrap asserts exactly once, on F→0. Press step during AUTO → no extra increment.
- **Priority:** press load (SW = 4'h3) and mode so their debounced events land in the same cycle → A = 3, auto_mode unchanged. In AUTO, load SW = 4'hE → A = E, the next increment comes 8 cycles later (A = F), then the following one gives A = 0 with wrap = 1.
- **Held through reset:** hold KEY_N[0] low, pulse RESET → after deassertion one step_pulse after 6 cycles, A = 1, then no further events while held.
